// File: rtl/cpu_pkg.sv
// cpu_pkg: types shared between the CPU datapath and the data-port memory.
//   cpu_word  - 32-bit machine word
//   mem_mode  - load/store access size carried on memMode
//   mem_rsp   - pending load response (fault flag + zero-extended data)
package cpu_pkg;

  typedef logic [31:0] cpu_word;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_mode;

  typedef struct packed {
    logic    fault;
    cpu_word data;
  } mem_rsp;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane steering for the data port.
//   memMode   in  access size (BYTE/HALF/WORD, 3 = reserved -> no lanes)
//   adr       in  low two bits of the byte address
//   storeData in  right-aligned store data
//   readWord  in  full word read from the RAM
//   byteEn    out per-byte write enables
//   storeWord out store data replicated onto the addressed lanes
//   loadWord  out addressed lanes extracted and zero-extended
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0] memMode,
  input  logic [1:0] adr,
  input  cpu_word    storeData,
  input  cpu_word    readWord,
  output logic [3:0] byteEn,
  output cpu_word    storeWord,
  output cpu_word    loadWord
);

  always_comb begin
    byteEn    = 4'b0000;
    storeWord = storeData;
    loadWord  = '0;
    case (mem_mode'(memMode))
      MEM_BYTE: begin
        byteEn    = 4'b0001 << adr;
        // Replicating the byte puts it on every lane; byteEn picks the one that lands.
        storeWord = {4{storeData[7:0]}};
        loadWord  = {24'h0, readWord[8*adr +: 8]};
      end
      MEM_HALF: begin
        byteEn    = adr[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{storeData[15:0]}};
        loadWord  = {16'h0, (adr[1] ? readWord[31:16] : readWord[15:0])};
      end
      MEM_WORD: begin
        byteEn    = 4'b1111;
        loadWord  = readWord;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder: data-port RAM responder for the CPU load/store port.
// Stores commit at the accepting edge; loads answer LATENCY cycles after
// acceptance with a one-cycle port2avail (or port2fault) strobe.
//   clk, reset  clock / async active-high reset (memory contents survive reset)
//   port2en     request valid, accepted when port2busy is low
//   port2WEn    1 = store, 0 = load
//   port2adr    byte address
//   port2i      right-aligned store data
//   memMode     access size (BYTE/HALF/WORD, 3 reserved)
//   port2o      zero-extended load data, meaningful while port2avail
//   port2avail  load data valid pulse
//   port2busy   request will not be accepted this cycle
//   port2fault  faulted request pulse (store: next cycle, load: response cycle)
module mem_port_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        port2en,
  input  logic        port2WEn,
  input  logic [31:0] port2adr,
  input  logic [31:0] port2i,
  input  logic [1:0]  memMode,
  output logic [31:0] port2o,
  output logic        port2avail,
  output logic        port2busy,
  output logic        port2fault
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  cpu_word mem [DEPTH_WORDS];

  logic [1:0]    state;
  logic [3:0]    cnt;
  mem_rsp        pend;

  logic          accept;
  logic          outOfRange;
  logic          misaligned;
  logic          reqFault;
  logic [AW-1:0] wordIdx;
  cpu_word       rdWord;
  logic [3:0]    byteEn;
  cpu_word       storeWord;
  cpu_word       loadWord;
  cpu_word       loadResult;

  assign accept     = port2en & ~port2busy;
  // adr >= 4*DEPTH_WORDS is the same as word index >= DEPTH_WORDS, with no overflow risk.
  assign outOfRange = (port2adr[31:2] >= 30'(DEPTH_WORDS));
  assign misaligned = ((memMode == MEM_HALF) && port2adr[0]) ||
                      ((memMode == MEM_WORD) && (port2adr[1:0] != 2'b00));
  assign reqFault   = (memMode == MEM_RSVD) || misaligned || outOfRange;
  assign wordIdx    = port2adr[AW+1:2];

  // The word is read at acceptance: nothing can write memory while a load is
  // outstanding, so sampling early and carrying the result is equivalent.
  assign rdWord     = outOfRange ? '0 : mem[wordIdx];
  assign loadResult = reqFault ? '0 : loadWord;

  mem_lane_align u_align (
    .memMode   (memMode),
    .adr       (port2adr[1:0]),
    .storeData (port2i),
    .readWord  (rdWord),
    .byteEn    (byteEn),
    .storeWord (storeWord),
    .loadWord  (loadWord)
  );

  // RAM has no reset; a request presented during reset must not write.
  always_ff @(posedge clk) begin
    if (!reset && accept && port2WEn && !reqFault) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pend       <= '0;
      port2o     <= '0;
      port2avail <= 1'b0;
      port2busy  <= 1'b0;
      port2fault <= 1'b0;
    end else begin
      port2avail <= 1'b0;
      port2fault <= 1'b0;
      port2busy  <= 1'b0;
      case (state)
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            port2avail <= ~pend.fault;
            port2fault <= pend.fault;
            port2o     <= pend.data;
          end else begin
            cnt       <= cnt - 4'd1;
            port2busy <= 1'b1;
          end
        end
        default: begin
          // IDLE and RESP behave alike: both accept, RESP just has the strobe up.
          state <= IDLE;
          if (accept) begin
            if (port2WEn) begin
              port2fault <= reqFault;
            end else if (LATENCY == 1) begin
              state      <= RESP;
              port2avail <= ~reqFault;
              port2fault <= reqFault;
              port2o     <= loadResult;
            end else begin
              state     <= WAIT;
              cnt       <= CNT_INIT;
              port2busy <= 1'b1;
              pend      <= '{fault: reqFault, data: loadResult};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench: three responders (LATENCY 2, 3, 1) driven against a byte-array model.
module tb_mem_port_responder;

  localparam int ND    = 3;
  localparam int DEPTH = 1024;
  localparam int WIN   = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        en   [ND];
  logic        we   [ND];
  logic [1:0]  mode [ND];
  logic [31:0] adr  [ND];
  logic [31:0] din  [ND];
  logic [31:0] dout [ND];
  logic        avail[ND];
  logic        busy [ND];
  logic        fault[ND];

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [ND][4*DEPTH];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : gd
      mem_port_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 3 : 1))
      ) dut (
        .clk        (clk),
        .reset      (reset),
        .port2en    (en[g]),
        .port2WEn   (we[g]),
        .port2adr   (adr[g]),
        .port2i     (din[g]),
        .memMode    (mode[g]),
        .port2o     (dout[g]),
        .port2avail (avail[g]),
        .port2busy  (busy[g]),
        .port2fault (fault[g])
      );
    end
  endgenerate

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  function automatic logic expFault(input int m, input logic [31:0] a);
    if (m == 3) return 1'b1;
    if ((a % (32'd1 << m)) != 0) return 1'b1;
    return a >= 32'(4*DEPTH);
  endfunction

  function automatic logic [31:0] expLoad(input int d, input int m, input logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < (1 << m); i++) v |= 32'(mdl[d][a+i]) << (8*i);
    return v;
  endfunction

  task automatic mdlStore(input int d, input int m, input logic [31:0] a, input logic [31:0] data);
    for (int i = 0; i < (1 << m); i++) mdl[d][a+i] = data[8*i +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then watches WIN cycles after acceptance.
  task automatic xact(input int d, input logic w, input logic [1:0] m, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output int nAv, output int nFl, output int nBz);
    int k = 0;
    while (busy[d] && k < 20) begin tick(); k++; end
    if (busy[d]) begin
      total++; bad++;
      $display("FAIL accept_timeout dut%0d busy=1 after 20 cycles, required 0", d);
    end
    en[d] = 1'b1; we[d] = w; mode[d] = m; adr[d] = a; din[d] = wd;
    tick();
    en[d] = 1'b0;
    lat = 0; rd = '0; nAv = 0; nFl = 0; nBz = 0;
    for (int c = 1; c <= WIN; c++) begin
      if ((avail[d] || fault[d]) && lat == 0) begin lat = c; rd = dout[d]; end
      if (avail[d]) nAv++;
      if (fault[d]) nFl++;
      if (busy[d])  nBz++;
      if (c < WIN) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < ND; d++) begin
      total++; if (dout[d]  !== 32'h0) begin bad++; $display("FAIL reset_o dut%0d got %h exp 0", d, dout[d]); end
      total++; if (avail[d] !== 1'b0)  begin bad++; $display("FAIL reset_avail dut%0d got %b exp 0", d, avail[d]); end
      total++; if (busy[d]  !== 1'b0)  begin bad++; $display("FAIL reset_busy dut%0d got %b exp 0", d, busy[d]); end
      total++; if (fault[d] !== 1'b0)  begin bad++; $display("FAIL reset_fault dut%0d got %b exp 0", d, fault[d]); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_store_load();
    int lat, nAv, nFl, nBz; logic [31:0] rd;
    xact(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, lat, rd, nAv, nFl, nBz);
    mdlStore(0, 2, 32'h10, 32'hDEADBEEF);
    total++; if (nAv != 0 || nFl != 0) begin bad++; $display("FAIL sw_strobes avail=%0d fault=%0d exp 0/0", nAv, nFl); end
    xact(0, 1'b0, 2'd2, 32'h10, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (lat != 2) begin bad++; $display("FAIL lw_latency got %0d exp 2", lat); end
    total++; if (nAv != 1 || nFl != 0) begin bad++; $display("FAIL lw_strobes avail=%0d fault=%0d exp 1/0", nAv, nFl); end
    total++; if (nBz != 1) begin bad++; $display("FAIL lw_busy got %0d cycles exp 1", nBz); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got %h exp deadbeef", rd); end
  endtask

  task automatic test_lanes();
    int lat, nAv, nFl, nBz; logic [31:0] rd;
    xact(0, 1'b1, 2'd2, 32'h20, 32'h11223344, lat, rd, nAv, nFl, nBz);
    mdlStore(0, 2, 32'h20, 32'h11223344);
    xact(0, 1'b1, 2'd0, 32'h22, 32'hFFFFFFAA, lat, rd, nAv, nFl, nBz);
    mdlStore(0, 0, 32'h22, 32'hFFFFFFAA);
    xact(0, 1'b0, 2'd2, 32'h20, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (rd !== 32'h11AA3344 || nAv != 1) begin bad++; $display("FAIL lane_lw got %h avail=%0d exp 11aa3344/1", rd, nAv); end
    xact(0, 1'b0, 2'd1, 32'h22, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (rd !== 32'h000011AA || nAv != 1) begin bad++; $display("FAIL lane_lh got %h avail=%0d exp 000011aa/1", rd, nAv); end
    xact(0, 1'b0, 2'd0, 32'h23, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (rd !== 32'h00000011 || nAv != 1) begin bad++; $display("FAIL lane_lb got %h avail=%0d exp 00000011/1", rd, nAv); end
  endtask

  task automatic test_faults();
    int lat, nAv, nFl, nBz; logic [31:0] rd;
    logic        fw [6];
    logic [1:0]  fm [6];
    logic [31:0] fa [6];
    logic [31:0] fd [6];
    fw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    fm = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    fa = '{32'h21, 32'h23, 32'(4*DEPTH), 32'h20, 32'(4*DEPTH), 32'h20};
    fd = '{32'h0, 32'hFFFF, 32'h0, 32'h0, 32'h0BADF00D, 32'h0};
    xact(0, 1'b1, 2'd2, 32'h0, 32'h01020304, lat, rd, nAv, nFl, nBz);
    mdlStore(0, 2, 32'h0, 32'h01020304);
    for (int i = 0; i < 6; i++) begin
      xact(0, fw[i], fm[i], fa[i], fd[i], lat, rd, nAv, nFl, nBz);
      total++; if (nFl != 1 || nAv != 0) begin bad++; $display("FAIL fault%0d_strobes fault=%0d avail=%0d exp 1/0", i, nFl, nAv); end
      total++; if (lat != (fw[i] ? 1 : 2)) begin bad++; $display("FAIL fault%0d_timing got %0d exp %0d", i, lat, fw[i] ? 1 : 2); end
      if (!fw[i]) begin
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL fault%0d_data got %h exp 0", i, rd); end
      end
    end
    xact(0, 1'b0, 2'd2, 32'h20, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (rd !== expLoad(0, 2, 32'h20)) begin bad++; $display("FAIL fault_readback20 got %h exp %h", rd, expLoad(0, 2, 32'h20)); end
    xact(0, 1'b0, 2'd2, 32'h0, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (rd !== expLoad(0, 2, 32'h0)) begin bad++; $display("FAIL fault_readback0 got %h exp %h", rd, expLoad(0, 2, 32'h0)); end
  endtask

  task automatic test_back_to_back();
    int lat, nAv, nFl, nBz; logic [31:0] rd;
    int avT[$]; logic [31:0] avD[$]; int bz, nf;
    xact(1, 1'b1, 2'd2, 32'h0, $urandom, lat, rd, nAv, nFl, nBz);
    mdlStore(1, 2, 32'h0, din[1]);
    xact(1, 1'b1, 2'd2, 32'h4, $urandom, lat, rd, nAv, nFl, nBz);
    mdlStore(1, 2, 32'h4, din[1]);
    for (int ph = 0; ph < 2; ph++) begin
      avT.delete(); avD.delete(); bz = 0; nf = 0;
      en[1] = 1'b1; we[1] = 1'b0; mode[1] = 2'd2; adr[1] = 32'h0;
      tick();
      for (int k = 1; k <= 12; k++) begin
        if (avail[1]) begin avT.push_back(k); avD.push_back(dout[1]); end
        if (busy[1])  bz++;
        if (fault[1]) nf++;
        if (k == 1)      begin adr[1] = 32'h4; en[1] = 1'b1; end
        else if (k == 3) en[1] = (ph == 1);
        else if (k > 3)  en[1] = 1'b0;
        tick();
      end
      total++; if (avT.size() != ph + 1 || nf != 0) begin bad++; $display("FAIL b2b%0d_count avail=%0d fault=%0d exp %0d/0", ph, avT.size(), nf, ph + 1); end
      total++; if (bz != 2 + 2*ph) begin bad++; $display("FAIL b2b%0d_busy got %0d exp %0d", ph, bz, 2 + 2*ph); end
      if (avT.size() >= 1) begin
        total++; if (avT[0] != 3 || avD[0] !== expLoad(1, 2, 32'h0)) begin bad++; $display("FAIL b2b%0d_first t=%0d d=%h exp 3/%h", ph, avT[0], avD[0], expLoad(1, 2, 32'h0)); end
      end
      if (avT.size() >= 2) begin
        total++; if (avT[1] - avT[0] != 3 || avD[1] !== expLoad(1, 2, 32'h4)) begin bad++; $display("FAIL b2b_second gap=%0d d=%h exp 3/%h", avT[1] - avT[0], avD[1], expLoad(1, 2, 32'h4)); end
      end
    end
  endtask

  task automatic test_reset_midload();
    int lat, nAv, nFl, nBz, cnt; logic [31:0] rd;
    en[0] = 1'b1; we[0] = 1'b0; mode[0] = 2'd2; adr[0] = 32'h10;
    tick();
    en[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (dout[0] !== 32'h0 || avail[0] !== 1'b0 || busy[0] !== 1'b0 || fault[0] !== 1'b0) begin
      bad++; $display("FAIL rst_async o=%h avail=%b busy=%b fault=%b exp all 0", dout[0], avail[0], busy[0], fault[0]);
    end
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (avail[0] || fault[0]) cnt++; end
    total++; if (cnt != 0) begin bad++; $display("FAIL rst_no_strobe got %0d strobes exp 0", cnt); end
    xact(0, 1'b0, 2'd2, 32'h10, 32'h0, lat, rd, nAv, nFl, nBz);
    total++; if (rd !== 32'hDEADBEEF || nAv != 1) begin bad++; $display("FAIL rst_mem_kept got %h avail=%0d exp deadbeef/1", rd, nAv); end
  endtask

  task automatic test_latency1();
    int lat, nAv, nFl, nBz; logic [31:0] rd; logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      xact(2, 1'b1, 2'd2, 32'(4*i), v, lat, rd, nAv, nFl, nBz);
      mdlStore(2, 2, 32'(4*i), v);
    end
    nAv = 0; nBz = 0;
    en[2] = 1'b1; we[2] = 1'b0; mode[2] = 2'd2; adr[2] = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (busy[2]) nBz++;
      if (avail[2]) begin
        nAv++;
        total++; if (dout[2] !== expLoad(2, 2, 32'(4*(k-1)))) begin bad++; $display("FAIL l1_data cyc%0d got %h exp %h", k, dout[2], expLoad(2, 2, 32'(4*(k-1)))); end
      end
      if (k < 8) adr[2] = 32'(4*k); else en[2] = 1'b0;
    end
    total++; if (nAv != 8) begin bad++; $display("FAIL l1_count got %0d exp 8", nAv); end
    total++; if (nBz != 0) begin bad++; $display("FAIL l1_busy got %0d exp 0", nBz); end
    // store immediately followed by a load of the same word
    v = $urandom;
    en[2] = 1'b1; we[2] = 1'b1; mode[2] = 2'd2; adr[2] = 32'h40; din[2] = v;
    tick();
    we[2] = 1'b0;
    tick();
    en[2] = 1'b0;
    total++; if (avail[2] !== 1'b1 || dout[2] !== v) begin bad++; $display("FAIL st_ld_fwd avail=%b d=%h exp 1/%h", avail[2], dout[2], v); end
    mdlStore(2, 2, 32'h40, v);
    tick();
  endtask

  task automatic test_random();
    int lat, nAv, nFl, nBz; logic [31:0] rd, a, wd; logic w, ef; int m;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        xact(d, 1'b1, 2'd2, 32'(4*i), wd, lat, rd, nAv, nFl, nBz);
        mdlStore(d, 2, 32'(4*i), wd);
      end
      for (int n = 0; n < 40; n++) begin
        w  = 1'($urandom_range(0, 1));
        m  = $urandom_range(0, 3);
        a  = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH) + $urandom_range(0, 15) : 32'($urandom_range(0, 63));
        wd = $urandom;
        ef = expFault(m, a);
        xact(d, w, 2'(m), a, wd, lat, rd, nAv, nFl, nBz);
        total++; if (nFl != int'(ef) || nAv != int'(!w && !ef)) begin bad++; $display("FAIL rnd_strobes dut%0d w=%b m=%0d a=%h fault=%0d avail=%0d", d, w, m, a, nFl, nAv); end
        total++; if (nBz != (w ? 0 : latOf(d) - 1)) begin bad++; $display("FAIL rnd_busy dut%0d got %0d exp %0d", d, nBz, w ? 0 : latOf(d) - 1); end
        if (!w) begin
          total++; if (lat != latOf(d)) begin bad++; $display("FAIL rnd_lat dut%0d got %0d exp %0d", d, lat, latOf(d)); end
          total++; if (rd !== (ef ? 32'h0 : expLoad(d, m, a))) begin bad++; $display("FAIL rnd_data dut%0d m=%0d a=%h got %h exp %h", d, m, a, rd, ef ? 32'h0 : expLoad(d, m, a)); end
        end else if (!ef) begin
          mdlStore(d, m, a, wd);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      en[d] = 1'b0; we[d] = 1'b0; mode[d] = 2'd0; adr[d] = '0; din[d] = '0;
    end
    test_reset();
    test_word_store_load();
    test_lanes();
    test_faults();
    test_back_to_back();
    test_reset_midload();
    test_latency1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
